restoring_div: RTL and testbench

Sequential unsigned restoring divider for the CPU arithmetic unit; it is the division counterpart of the Booth multiplier. The block accepts a dividend/divisor pair on a single-cycle start pulse and iterates one quotient bit per two clock cycles using shift and subtract/restore steps. It returns quotient, remainder and a done pulse. It contains a small control FSM with an iteration counter driving an (N+1)-bit partial-remainder register, a quotient register and a divisor register.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_uc.sv | 89 ++++++++
 rtl/restoring_div.sv | 106 ++++++++++
 tb/tb_restoring_div.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package div_pkg;

  localparam int DIV_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SUB   = 2'd2,
    ST_DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_uc.sv
// Control unit of the restoring divider: state machine plus iteration counter,
// producing load/shift/sub_step/fin strobes for the datapath.
module div_uc
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic divisor_zero,
  output logic load,
  output logic shift,
  output logic sub_step,
  output logic fin
);

  localparam int CW = $clog2(N + 1);

  div_state_t    state;
  logic [CW-1:0] cnt;

  // Start is only honoured in IDLE, so load must react within the same cycle.
  assign load = (state == ST_IDLE) && start;

  // State, iteration counter and registered step strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= {CW{1'b0}};
      shift    <= 1'b0;
      sub_step <= 1'b0;
      fin      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sub_step <= 1'b0;
          fin      <= 1'b0;
          if (start) begin
            cnt <= CW'(N);
            if (divisor_zero) begin
              state <= ST_DONE;
              shift <= 1'b0;
            end else begin
              state <= ST_SHIFT;
              shift <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
            shift <= 1'b0;
          end
        end
        ST_SHIFT: begin
          state    <= ST_SUB;
          shift    <= 1'b0;
          sub_step <= 1'b1;
          // fin marks the subtract that produces the final quotient bit
          fin      <= (cnt == CW'(1));
        end
        ST_SUB: begin
          cnt      <= cnt - CW'(1);
          sub_step <= 1'b0;
          fin      <= 1'b0;
          if (cnt == CW'(1)) begin
            state <= ST_DONE;
            shift <= 1'b0;
          end else begin
            state <= ST_SHIFT;
            shift <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          shift    <= 1'b0;
          sub_step <= 1'b0;
          fin      <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= {CW{1'b0}};
          shift    <= 1'b0;
          sub_step <= 1'b0;
          fin      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/restoring_div.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/SUB pair,
// with registered quotient, remainder and status outputs.
module restoring_div
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  logic         load;
  logic         shift;
  logic         sub_step;
  logic         fin;
  logic         divisor_zero;
  logic [N:0]   a;
  logic [N-1:0] q;
  logic [N-1:0] m;
  logic [N:0]   t;
  logic [N:0]   a_next;
  logic [N-1:0] q_next;

  assign divisor_zero = (divisor == {N{1'b0}});

  div_uc #(.N(N)) u_uc (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .divisor_zero (divisor_zero),
    .load         (load),
    .shift        (shift),
    .sub_step     (sub_step),
    .fin          (fin)
  );

  // Trial subtraction; a set MSB of t means the divisor did not fit, so restore.
  always_comb begin
    t      = a - {1'b0, m};
    a_next = a;
    q_next = q;
    if (t[N] == 1'b0) begin
      a_next = t;
      q_next = {q[N-1:1], 1'b1};
    end else begin
      a_next = a;
      q_next = {q[N-1:1], 1'b0};
    end
  end

  // A/Q/M datapath and result/status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a           <= {(N+1){1'b0}};
      q           <= {N{1'b0}};
      m           <= {N{1'b0}};
      quotient    <= {N{1'b0}};
      remainder   <= {N{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a    <= {(N+1){1'b0}};
        q    <= dividend;
        m    <= divisor;
        busy <= 1'b1;
        if (divisor_zero) begin
          quotient    <= {N{1'b1}};
          remainder   <= dividend;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end else begin
          div_by_zero <= 1'b0;
        end
      end else if (shift) begin
        {a, q} <= {a[N-1:0], q, 1'b0};
      end else if (sub_step) begin
        a <= a_next;
        q <= q_next;
        // Results are captured on the final step so they appear with done.
        if (fin) begin
          quotient  <= q_next;
          remainder <= a_next[N-1:0];
          done      <= 1'b1;
        end else begin
          done <= 1'b0;
        end
      end else if (done) begin
        busy <= 1'b0;
      end else begin
        busy <= busy;
      end
    end
  end

endmodule

// File: tb/tb_restoring_div.sv
// Self-checking bench for restoring_div: directed cases, start-while-busy,
// mid-operation reset, random pairs and an exhaustive N=4 sweep.
module tb_restoring_div;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  restoring_div #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full division from start pulse to the cycle after done, checked
  // against plain / and % (all-ones quotient and dividend remainder for /0).
  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    int           lat;
    int           exp_lat;
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         ez;
    ez      = (b == 0);
    eq      = ez ? {N{1'b1}} : N'(int'(a) / int'(b));
    er      = ez ? a : N'(int'(a) % int'(b));
    exp_lat = ez ? 0 : 2 * N;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, " done_latency"}, lat, exp_lat);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, ez);
    check({tag, " busy_in_done"}, busy, 1);
    @(posedge clk);
    #1;
    check({tag, " done_single"}, done, 0);
    check({tag, " busy_fall"}, busy, 0);
    check({tag, " quotient_hold"}, quotient, eq);
    check({tag, " remainder_hold"}, remainder, er);
  endtask

  initial begin
    int           dones;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst quotient", quotient, 0);
    check("rst remainder", remainder, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst dz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b1;

    do_div(4'd13, 4'd4, "13/4");
    do_div(4'd15, 4'd1, "15/1");
    do_div(4'd3, 4'd7, "3/7");
    do_div(4'd15, 4'd15, "15/15");
    do_div(4'd0, 4'd5, "0/5");
    do_div(4'd9, 4'd0, "9/0");
    do_div(4'd6, 4'd3, "6/3");

    // Start while busy is ignored
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 4'd2; divisor = 4'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("busy_start done_count", dones, 1);
    check("busy_start quotient", quotient, 3);
    check("busy_start remainder", remainder, 1);

    // Reset in the middle of a division
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst dz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("midrst no_done", dones, 0);
    do_div(4'd10, 4'd3, "10/3");

    // Random pairs
    for (int i = 0; i < 20; i++) begin
      ra = N'($urandom_range(0, 15));
      rb = N'($urandom_range(0, 15));
      do_div(ra, rb, "rand");
    end

    // Exhaustive sweep
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_div(N'(x), N'(y), "sweep");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
